y86_alu: RTL and testbench

- 64-bit arithmetic/logic unit for the Y86-64 SEQ execute stage.
- Computes add, subtract, AND or XOR of two signed 64-bit operands under a 2-bit control code.
- Registers the result, the overflow indication and an optional condition-code update.
- The execute stage drives a/b from valA/valB/valC/constant 8 and uses y as valE; the registered ZF/SF/OF feed the jXX/cmovXX condition logic.

---
 rtl/y86_alu.sv | 54 +++++
 tb/tb_y86_alu.sv | 121 ++++++++++++
 2 files changed

// File: rtl/y86_alu.sv
// y86_alu: 64-bit Y86-64 execute-stage ALU with a registered result, an overflow flag and ZF/SF/OF condition codes
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       control,
    input  logic             set_cc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             out_valid,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam int MSB = WIDTH - 1;
    logic [WIDTH-1:0] sum, diff, res;
    logic ovf;
    // select the operation result and its signed overflow; the logic ops never overflow
    always_comb begin
        sum  = a + b;
        diff = a - b;
        res  = control == 2'd0 ? sum  :
               control == 2'd1 ? diff :
               control == 2'd2 ? (a & b) : (a ^ b);
        ovf  = control == 2'd0 ? (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB])  :
               control == 2'd1 ? (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) : 1'b0;
    end
    // register result, valid pulse and condition codes; flags update together only on a valid set_cc op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y         <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            zf        <= 1'b0;
            sf        <= 1'b0;
            of        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y        <= res;
                overflow <= ovf;
                if (set_cc) begin
                    zf <= res == '0;
                    sf <= res[MSB];
                    of <= ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: directed and randomized checks of y86_alu against an exact-arithmetic reference model
module tb_y86_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  control = 2'd0;
    logic        set_cc = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [63:0] y;
    logic        overflow, out_valid, zf, sf, of;

    int total = 0;
    int passed = 0;
    int fails = 0;

    logic [63:0] m_y = '0;
    logic        m_ovf = 1'b0, m_ov = 1'b0, m_zf = 1'b0, m_sf = 1'b0, m_of = 1'b0;

    localparam logic signed [65:0] MAXV = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MINV = -MAXV - 66'sd1;

    y86_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .control(control), .set_cc(set_cc),
        .a(a), .b(b), .y(y), .overflow(overflow), .out_valid(out_valid),
        .zf(zf), .sf(sf), .of(of)
    );

    always #5 clk = ~clk;

    // exact wide arithmetic: overflow means the true signed result does not fit in 64 bits
    function automatic void model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] z,
                                  output logic [63:0] r, output logic v);
        logic signed [65:0] xs, zs, e;
        xs = {{2{x[63]}}, x};
        zs = {{2{z[63]}}, z};
        e = '0;
        if (c == 2'd0) e = xs + zs;
        else if (c == 2'd1) e = xs - zs;
        r = c == 2'd2 ? (x & z) : c == 2'd3 ? (x ^ z) : e[63:0];
        v = (c < 2'd2) && ((e > MAXV) || (e < MINV));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string name, input logic rn, input logic iv, input logic [1:0] c,
                        input logic sc, input logic [63:0] x, input logic [63:0] z);
        logic [63:0] r;
        logic v;
        @(negedge clk);
        rst_n = rn; in_valid = iv; control = c; set_cc = sc; a = x; b = z;
        @(posedge clk);
        #1;
        model(c, x, z, r, v);
        if (!rn) begin
            m_y = '0; m_ovf = 0; m_ov = 0; m_zf = 0; m_sf = 0; m_of = 0;
        end else begin
            m_ov = iv;
            if (iv) begin
                m_y = r; m_ovf = v;
                if (sc) begin m_zf = (r == 64'd0); m_sf = r[63]; m_of = v; end
            end
        end
        chk({name, ".y"}, y, m_y);
        chk({name, ".overflow"}, {63'd0, overflow}, {63'd0, m_ovf});
        chk({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_ov});
        chk({name, ".zf"}, {63'd0, zf}, {63'd0, m_zf});
        chk({name, ".sf"}, {63'd0, sf}, {63'd0, m_sf});
        chk({name, ".of"}, {63'd0, of}, {63'd0, m_of});
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] corners [8];
        corners = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 64'h2};
        return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : {$urandom, $urandom};
    endfunction

    initial begin
        step("rst0", 0, 1, 2'd0, 1, 64'd5, 64'd3);
        step("rst1", 0, 1, 2'd0, 1, 64'd5, 64'd3);
        chk("rst.y_const", y, 64'd0);
        chk("rst.zf_const", {63'd0, zf}, 64'd0);
        step("add_ovf", 1, 1, 2'd0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_ovf.y_const", y, 64'h8000_0000_0000_0000);
        chk("add_ovf.of_const", {63'd0, of}, 64'd1);
        step("sub_zero", 1, 1, 2'd1, 1, 64'h10, 64'h10);
        chk("sub_zero.zf_const", {63'd0, zf}, 64'd1);
        step("sub_ovf", 1, 1, 2'd1, 0, 64'h8000_0000_0000_0000, 64'd1);
        chk("sub_ovf.y_const", y, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_ovf.overflow_const", {63'd0, overflow}, 64'd1);
        step("and", 1, 1, 2'd2, 0, 64'hF0F0, 64'hFF00);
        chk("and.y_const", y, 64'hF000);
        step("xor", 1, 1, 2'd3, 0, 64'hF0F0, 64'hFF00);
        chk("xor.y_const", y, 64'h0FF0);
        step("cc_hold", 1, 1, 2'd0, 0, -64'sd8, 64'd3);
        chk("cc_hold.y_const", y, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("cc_hold.zf_const", {63'd0, zf}, 64'd1);
        step("b2b_add", 1, 1, 2'd0, 1, 64'd1, 64'd2);
        step("b2b_sub", 1, 1, 2'd1, 1, 64'd2, 64'd5);
        chk("b2b_sub.y_const", y, 64'hFFFF_FFFF_FFFF_FFFD);
        step("b2b_xor", 1, 1, 2'd3, 1, 64'd6, 64'd6);
        step("idle", 1, 0, 2'd0, 1, 64'd9, 64'd9);
        chk("idle.y_const", y, 64'd0);
        chk("idle.out_valid_const", {63'd0, out_valid}, 64'd0);
        step("ignored_cc", 1, 0, 2'd0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
